// File: rtl/ir_pkg.sv
// Shared types for the input-router address generator: FSM states and the
// coordinate record carried through the coordinate queue.
package ir_pkg;

   localparam int IR_ADDR_W = 8;
   localparam int IR_ROW_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      GEN
   } ag_state_t;

   typedef struct packed {
      logic [IR_ADDR_W-1:0] x;
      logic [IR_ADDR_W-1:0] y;
      logic [IR_ROW_W-1:0]  row_id;
   } ir_coord_t;

endpackage

// File: rtl/ir_coord_fifo.sv
// Small synchronous FIFO of window coordinates. A push into a full queue is
// accepted when a pop happens in the same cycle, since the head slot frees up.
module ir_coord_fifo
   import ir_pkg::*;
#(
   parameter int  CQ_DEPTH = 4,
   localparam int PTR_W    = $clog2(CQ_DEPTH),
   localparam int CNT_W    = $clog2(CQ_DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_push,
   input  ir_coord_t        i_data,
   input  logic             i_pop,
   output ir_coord_t        o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   ir_coord_t        r_mem [CQ_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full    = (r_count == CNT_W'(CQ_DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Pointer and occupancy bookkeeping; pointers wrap naturally because the depth is a power of two
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ir_addr_gen.sv
// Input-router address generator: queues window origins and expands each one
// into its K x K feature-map addresses, row-major, on a valid/ready stream.
// The coordinate record widths come from ir_pkg, so ADDR_WIDTH and ROW_COUNT
// must match IR_ADDR_W and IR_ROW_W.
module ir_addr_gen
   import ir_pkg::*;
#(
   parameter int ROW_COUNT  = IR_ROW_W,
   parameter int ADDR_WIDTH = IR_ADDR_W,
   parameter int K_WIDTH    = 4,
   parameter int CQ_DEPTH   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_reg_clear,
   input  logic                  i_en,
   input  logic [ADDR_WIDTH-1:0] i_o_x,
   input  logic [ADDR_WIDTH-1:0] i_o_y,
   input  logic [ROW_COUNT-1:0]  i_row_id,
   input  logic [ADDR_WIDTH-1:0] i_start_addr,
   input  logic [ADDR_WIDTH-1:0] i_i_size,
   input  logic [K_WIDTH-1:0]    i_k_size,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [ROW_COUNT-1:0]  o_row_id,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_full,
   output logic                  o_overflow,
   output logic                  o_idle
);

   localparam int CNT_W = $clog2(CQ_DEPTH) + 1;

   ag_state_t             r_state;
   logic [ADDR_WIDTH-1:0] r_x;
   logic [ADDR_WIDTH-1:0] r_y;
   logic [ADDR_WIDTH-1:0] r_i_size;
   logic [ADDR_WIDTH-1:0] r_row_base;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ROW_COUNT-1:0]  r_row_id;
   logic [K_WIDTH-1:0]    r_keff;
   logic [K_WIDTH-1:0]    r_kx;
   logic [K_WIDTH-1:0]    r_ky;
   logic                  r_valid;
   logic                  r_overflow;

   logic                  w_clr;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [CNT_W-1:0]      w_count;
   ir_coord_t             w_push_coord;
   ir_coord_t             w_head;
   logic [ADDR_WIDTH-1:0] w_base;
   logic                  w_kx_last;
   logic                  w_ky_last;

   assign w_clr               = i_rst || i_reg_clear;
   assign w_pop               = (r_state == IDLE) && !w_empty;
   assign w_push_coord.x      = i_o_x;
   assign w_push_coord.y      = i_o_y;
   assign w_push_coord.row_id = i_row_id;
   assign w_base              = i_start_addr + r_y * i_i_size + r_x;
   assign w_kx_last           = (r_kx == r_keff - K_WIDTH'(1));
   assign w_ky_last           = (r_ky == r_keff - K_WIDTH'(1));

   ir_coord_fifo #(
      .CQ_DEPTH (CQ_DEPTH)
   ) u_coord_fifo (
      .i_clk   (i_clk),
      .i_clr   (w_clr),
      .i_push  (i_en),
      .i_data  (w_push_coord),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Sticky flag recording that a coordinate was dropped because the queue was full
   always_ff @(posedge i_clk) begin
      if (w_clr) begin
         r_overflow <= 1'b0;
      end else if (i_en && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end
   end

   // Window expansion FSM: pop a coordinate, compute the window base, then walk kx inside ky
   always_ff @(posedge i_clk) begin
      if (w_clr) begin
         r_state    <= IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_i_size   <= '0;
         r_row_base <= '0;
         r_addr     <= '0;
         r_row_id   <= '0;
         r_keff     <= '0;
         r_kx       <= '0;
         r_ky       <= '0;
         r_valid    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_x      <= w_head.x;
                  r_y      <= w_head.y;
                  r_row_id <= w_head.row_id;
                  r_state  <= LOAD;
               end
            end
            LOAD: begin
               r_keff     <= (i_k_size == '0) ? K_WIDTH'(1) : i_k_size;
               r_i_size   <= i_i_size;
               r_row_base <= w_base;
               r_addr     <= w_base;
               r_kx       <= '0;
               r_ky       <= '0;
               r_valid    <= 1'b1;
               r_state    <= GEN;
            end
            GEN: begin
               if (r_valid && i_ready) begin
                  if (!w_kx_last) begin
                     r_kx   <= r_kx + K_WIDTH'(1);
                     r_addr <= r_row_base + ADDR_WIDTH'(r_kx) + ADDR_WIDTH'(1);
                  end else if (w_ky_last) begin
                     r_kx    <= '0;
                     r_valid <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_kx       <= '0;
                     r_ky       <= r_ky + K_WIDTH'(1);
                     r_row_base <= r_row_base + r_i_size;
                     r_addr     <= r_row_base + r_i_size;
                  end
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_addr     = r_addr;
   assign o_row_id   = r_row_id;
   assign o_valid    = r_valid;
   assign o_full     = w_full;
   assign o_overflow = r_overflow;
   assign o_idle     = (r_state == IDLE) && (w_count == '0);

endmodule

// File: doc/ir_addr_gen.md
Name: ir_addr_gen

Overview:
- Input-router address generator. Sits directly downstream of the input-router controller's coordinate stream, which supplies input-space window origins (x, y) and a row id, with stride already applied.
- For each coordinate it emits the K×K input-feature-map addresses of the convolution window, tagged with the row id, on a valid/ready stream toward the row routers' address FIFOs.
- Buffers coordinates in a small queue, because the controller issues one coordinate per cycle while expansion takes K×K cycles.

Parameters:
- ROW_COUNT, 4, width of the row-id field (matches upstream row-id port width).
- ADDR_WIDTH, 8, width of addresses, coordinates and sizes.
- K_WIDTH, 4, width of the kernel-size input.
- CQ_DEPTH, 4, coordinate queue depth (power of two, ≥2).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_reg_clear  in  1  synchronous clear, identical effect to i_rst
- i_en  in  1  coordinate push strobe (driven by controller ag_en)
- i_o_x  in  ADDR_WIDTH  window origin column (input space)
- i_o_y  in  ADDR_WIDTH  window origin row (input space)
- i_row_id  in  ROW_COUNT  destination row-router id
- i_start_addr  in  ADDR_WIDTH  feature-map base address
- i_i_size  in  ADDR_WIDTH  input feature-map row pitch
- i_k_size  in  K_WIDTH  kernel size K
- o_addr  out  ADDR_WIDTH  generated address
- o_row_id  out  ROW_COUNT  row id of current window
- o_valid  out  1  o_addr/o_row_id valid
- i_ready  in  1  consumer accepts
- o_full  out  1  coordinate queue full
- o_overflow  out  1  sticky: push dropped while full
- o_idle  out  1  FSM in IDLE and queue empty

Behaviour:
- Reset / i_reg_clear: all outputs 0 except o_idle=1. Queue emptied, FSM→IDLE, counters 0, any in-flight window discarded.
- Queue push when i_en=1 and (not full, or a pop occurs in the same cycle).
  - Push while full with no pop: entry dropped, o_overflow←1 until reset/clear.
- FSM states: IDLE, LOAD, GEN.
  - IDLE: queue non-empty → pop head, latch x, y, row_id → LOAD.
  - LOAD: Keff = (i_k_size==0) ? 1 : i_k_size; base = i_start_addr + y*i_i_size + x; row_base←base; kx←0; ky←0 → GEN.
  - GEN: o_valid=1, o_addr = row_base + kx, o_row_id = latched id. On handshake (o_valid && i_ready):
    - if kx<Keff-1: kx+1;
    - else kx←0, ky+1, row_base←row_base+i_i_size;
    - on the last handshake (kx=Keff-1, ky=Keff-1) → IDLE.
- All address arithmetic is truncated mod 2^ADDR_WIDTH (wraps silently).
- i_start_addr, i_i_size and i_k_size are sampled in LOAD only; they must stay stable for a window's lifetime.
- Latency: coordinate accepted at edge t with FSM idle → o_valid high after edge t+2. After the last address of a window there is one IDLE cycle and one LOAD cycle (o_valid=0) before the next window.
- Addresses are issued in row-major order: ky outer, kx inner.
- Backpressure: while i_ready=0, o_addr, o_row_id and o_valid hold stable.
- o_valid, o_addr and o_row_id are driven from registers only; there is no combinational path from i_ready or i_en.
- o_full = (count==CQ_DEPTH). o_idle = (state==IDLE && count==0).

Decomposition:
- Package ir_pkg:
  - ag_state_t enum {IDLE, LOAD, GEN};
  - ir_coord_t packed struct {x, y, row_id}.
- Sub-module ir_coord_fifo: synchronous FIFO of ir_coord_t.
  - Parameter CQ_DEPTH; push/pop/full/empty/count.
  - Same-cycle push+pop when full is allowed.

Test Plan:
- K=3, i_i_size=8, i_start_addr=16, push (x=2, y=1, row=0), i_ready=1 → o_addr 26, 27, 28, 34, 35, 36, 42, 43, 44 on 9 consecutive valid cycles, o_row_id=0, then o_idle=1.
- Same stimulus, i_ready=0 for 3 cycles while o_addr=28 → 28 held stable with o_valid=1; full sequence unchanged; 9 handshakes total.
- K=3, push 6 coordinates on consecutive edges 0–5 → first 5 accepted (one popped at edge 1), 6th dropped, o_full=1 at edge 5, o_overflow=1; exactly 45 addresses emitted, in push order.
- Wrap: i_start_addr=250, i_i_size=8, x=4, y=0, K=2 → o_addr 254, 255, 6, 7.
- i_rst (or i_reg_clear) asserted after the 4th address of a K=3 window → next cycle o_valid=0, o_idle=1, o_full=0, o_overflow=0; no further addresses emitted.
- i_k_size=0, x=1, y=1, i_i_size=8, i_start_addr=0 → exactly one address, 9, then IDLE.
